seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for a DIGITS-digit common-anode/cathode 7-segment display.

---
 rtl/seg_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: frame-synchronous snapshot of digit codes,
// per-slot dead time for anti-ghosting, and registered polarity-adjusted pin outputs.
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 8,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [5*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = {7{SEG_ACT_LOW}};
  localparam logic              DP_OFF    = SEG_ACT_LOW;
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{DIG_ACT_LOW}};

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              term_cyc;
  logic              snap;

  logic [4:0]        shadow_q    [DIGITS];
  logic              shadow_dp_q [DIGITS];

  logic [4:0]        code_sel;
  logic              dp_sel;
  logic              digit_on;
  logic [DIGITS-1:0] an_l;
  logic [6:0]        seg_l;
  logic              dp_l;

  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'h00:   pat = 7'b0111111;
      5'h01:   pat = 7'b0000110;
      5'h02:   pat = 7'b1011011;
      5'h03:   pat = 7'b1001111;
      5'h04:   pat = 7'b1100110;
      5'h05:   pat = 7'b1101101;
      5'h06:   pat = 7'b1111101;
      5'h07:   pat = 7'b0000111;
      5'h08:   pat = 7'b1111111;
      5'h09:   pat = 7'b1101111;
      5'h0A:   pat = 7'b1011111;
      5'h0B:   pat = 7'b1111100;
      5'h0C:   pat = 7'b0111001;
      5'h0D:   pat = 7'b1011110;
      5'h0E:   pat = 7'b1111011;
      5'h0F:   pat = 7'b1110001;
      5'h10:   pat = 7'b1000000;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  // The prescaler and digit index free-run regardless of en so re-enable resumes in place.
  assign term_cyc = (cnt_q == CNT_LAST);
  assign snap     = term_cyc && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = term_cyc ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (term_cyc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= snap;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_shadow
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        shadow_q[gi]    <= 5'h1F;
        shadow_dp_q[gi] <= 1'b0;
      end else if (snap) begin
        shadow_q[gi]    <= num[5*gi +: 5];
        shadow_dp_q[gi] <= dp[gi];
      end
    end
  end

  always_comb begin
    code_sel = 5'h1F;
    dp_sel   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        code_sel = shadow_q[i];
        dp_sel   = shadow_dp_q[i];
      end
    end
  end

  assign digit_on = en && (cnt_q >= BLANK_END);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
    assign an_l[gi] = digit_on && (idx_q == IDX_W'(gi));
  end

  always_comb begin
    seg_l = digit_on ? decode(code_sel) : 7'b0000000;
    dp_l  = digit_on && dp_sel;
    seg_d = SEG_ACT_LOW ? ~seg_l : seg_l;
    dp_d  = SEG_ACT_LOW ? ~dp_l  : dp_l;
    an_d  = DIG_ACT_LOW ? ~an_l  : an_l;
  end

  // Pin-facing registers: polarity is applied here so the pins never glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboarded bench: a 4-digit active-high-segment instance and a 1-digit all-active-low
// instance run side by side; expected pin values are queued per cycle and checked by a monitor.
module tb_seg_scan_driver;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en;
  logic [19:0] num;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  logic        en2;
  logic [4:0]  num2;
  logic        dp2;
  logic [6:0]  seg2;
  logic        dp_out2;
  logic        an2;
  logic        frame_done2;

  typedef struct packed {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       an2;
    logic [6:0] seg2;
    logic       dp2;
    logic       fd2;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Expected-side state: output cycle number since reset and the codes now on display.
  int         k;
  logic [4:0] disp [4];
  logic [3:0] disp_dp;
  logic [4:0] disp2;
  logic       disp2_dp;

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .num(num), .dp(dp),
    .seg(seg), .dp_out(dp_out), .an(an), .frame_done(frame_done)
  );

  seg_scan_driver #(
    .DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut_low (
    .CLK(CLK), .RST(RST), .en(en2), .num(num2), .dp(dp2),
    .seg(seg2), .dp_out(dp_out2), .an(an2), .frame_done(frame_done2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'h00: return 7'b0111111;  5'h01: return 7'b0000110;
      5'h02: return 7'b1011011;  5'h03: return 7'b1001111;
      5'h04: return 7'b1100110;  5'h05: return 7'b1101101;
      5'h06: return 7'b1111101;  5'h07: return 7'b0000111;
      5'h08: return 7'b1111111;  5'h09: return 7'b1101111;
      5'h0A: return 7'b1011111;  5'h0B: return 7'b1111100;
      5'h0C: return 7'b0111001;  5'h0D: return 7'b1011110;
      5'h0E: return 7'b1111011;  5'h0F: return 7'b1110001;
      5'h10: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    k = 0;
    for (int i = 0; i < 4; i++) disp[i] = 5'h1F;
    disp_dp  = 4'b0000;
    disp2    = 5'h1F;
    disp2_dp = 1'b0;
  endtask

  // Called on a falling edge with this cycle's inputs already driven; queues the pin
  // values expected after the next rising edge, then moves to the next falling edge.
  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      exp_t e;
      int   p, slot, c, p2;
      logic act, act2;
      k++;
      p    = (k - 1) % 16;
      slot = p / 4;
      c    = p % 4;
      act  = (c != 0) && en;
      e.k   = k;
      e.an  = act ? ~(4'b0001 << slot) : 4'b1111;
      e.seg = act ? glyph(disp[slot]) : 7'b0000000;
      e.dp  = act ? disp_dp[slot] : 1'b0;
      e.fd  = (p == 15);
      p2    = (k - 1) % 4;
      act2  = (p2 != 0) && en2;
      e.an2  = ~act2;
      e.seg2 = act2 ? ~glyph(disp2) : 7'b1111111;
      e.dp2  = act2 ? ~disp2_dp : 1'b1;
      e.fd2  = (p2 == 3);
      sb.push_back(e);
      if (p == 15) begin
        for (int i = 0; i < 4; i++) disp[i] = num[5*i +: 5];
        disp_dp = dp;
      end
      if (p2 == 3) begin
        disp2    = num2;
        disp2_dp = dp2;
      end
      @(negedge CLK);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("an",          e.k, 32'(an),          32'(e.an));
        chk("seg",         e.k, 32'(seg),         32'(e.seg));
        chk("dp_out",      e.k, 32'(dp_out),      32'(e.dp));
        chk("frame_done",  e.k, 32'(frame_done),  32'(e.fd));
        chk("an_low",      e.k, 32'(an2),         32'(e.an2));
        chk("seg_low",     e.k, 32'(seg2),        32'(e.seg2));
        chk("dp_out_low",  e.k, 32'(dp_out2),     32'(e.dp2));
        chk("fdone_low",   e.k, 32'(frame_done2), 32'(e.fd2));
      end
    end
  end

  initial begin : stimulus
    en   = 1'b0;
    num  = 20'hFFFFF;
    dp   = 4'b0000;
    en2  = 1'b0;
    num2 = 5'h1F;
    dp2  = 1'b0;
    reset_model();
    repeat (3) @(negedge CLK);

    chk("rst_an",       0, 32'(an),          32'h0000000F);
    chk("rst_seg",      0, 32'(seg),         32'h00000000);
    chk("rst_dp_out",   0, 32'(dp_out),      32'h00000000);
    chk("rst_fdone",    0, 32'(frame_done),  32'h00000000);
    chk("rst_an_low",   0, 32'(an2),         32'h00000001);
    chk("rst_seg_low",  0, 32'(seg2),        32'h0000007F);
    chk("rst_dp_low",   0, 32'(dp_out2),     32'h00000001);

    // Basic scan: blank first frame, then digits 0..3 showing 0,1,2,3; minus on the single digit.
    RST  = 1'b0;
    en   = 1'b1;
    num  = {5'd3, 5'd2, 5'd1, 5'd0};
    en2  = 1'b1;
    num2 = 5'h10;
    dp2  = 1'b1;
    tick(32);

    // Sweep every code on digit 0, with its decimal point lit on odd codes.
    for (int c = 0; c < 32; c++) begin
      num  = {5'h0F, 5'h0E, 5'h0D, 5'(c)};
      dp   = {3'b000, c[0]};
      num2 = 5'(c);
      dp2  = ~c[0];
      tick(16);
    end
    tick(16);

    // Mid-frame change while digit 1 is on: display holds until the next frame boundary.
    num = {5'h0A, 5'h0B, 5'h0C, 5'h0D};
    dp  = 4'b1010;
    tick(16);
    tick(5);
    num = {5'h10, 5'h11, 5'h09, 5'h08};
    dp  = 4'b0101;
    tick(11);
    tick(16);

    // Enable dropped for 10 cycles mid-slot, then scanning resumes in place.
    tick(6);
    en  = 1'b0;
    en2 = 1'b0;
    tick(10);
    en  = 1'b1;
    en2 = 1'b1;
    tick(16);

    // Asynchronous reset between clock edges.
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_an",      -1, 32'(an),          32'h0000000F);
    chk("arst_seg",     -1, 32'(seg),         32'h00000000);
    chk("arst_dp_out",  -1, 32'(dp_out),      32'h00000000);
    chk("arst_fdone",   -1, 32'(frame_done),  32'h00000000);
    chk("arst_an_low",  -1, 32'(an2),         32'h00000001);
    chk("arst_seg_low", -1, 32'(seg2),        32'h0000007F);
    @(negedge CLK);
    RST = 1'b0;
    reset_model();
    tick(32);

    @(posedge CLK);
    #2;
    chk("queue_drained", k, 32'(sb.size()), 32'h00000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
